// File: rtl/tug_press_conditioner.sv
// Tug-of-war player input front end: synchronizes, debounces and edge-detects two
// raw active-low pushbuttons into one-cycle move pulses and clean held levels.

module tug_press_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    input  logic enable_i,
    output logic pulse_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        LOCKOUT,
        RELEASED,
        PRESSED
    } state_e;

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] primed_q;
    logic [SYNC_STAGES-1:0] primed_d;
    logic                   synced;
    logic                   primed;
    logic                   db_q;
    logic                   db_d;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic [7:0]             cnt_inc;
    logic                   accept;
    state_e                 state_q;
    logic                   pulse_q;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign primed  = primed_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + 8'd1;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], ~key_n_i};
        primed_d = {primed_q[SYNC_STAGES-2:0], 1'b1};
        accept   = 1'b0;
        db_d     = db_q;
        cnt_d    = 8'd0;
        if (synced != db_q) begin
            if (cnt_inc == DB_LIMIT) begin
                accept = 1'b1;
                db_d   = synced;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the synchronizer chain is reset like ordinary state; it is flops, not a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            primed_q <= '0;
            db_q     <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            sync_q   <= sync_d;
            primed_q <= primed_d;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
        end
    end

    // primed marks that synced now carries a real sample rather than the reset
    // value, so a key held through reset keeps the channel locked out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOCKOUT;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                LOCKOUT: begin
                    if (primed && !db_q && !synced) begin
                        state_q <= RELEASED;
                    end
                end
                RELEASED: begin
                    if (accept && synced) begin
                        state_q <= PRESSED;
                        pulse_q <= enable_i;
                    end
                end
                PRESSED: begin
                    if (accept && !synced) begin
                        state_q <= RELEASED;
                    end
                end
                default: state_q <= LOCKOUT;
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign held_o  = db_q;

endmodule

module tug_press_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic enable,
    output logic L,
    output logic R,
    output logic held_l,
    output logic held_r
);

    tug_press_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_l_n),
        .enable_i(enable),
        .pulse_o (L),
        .held_o  (held_l)
    );

    tug_press_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_r_n),
        .enable_i(enable),
        .pulse_o (R),
        .held_o  (held_r)
    );

endmodule

// File: tb/tb_tug_press_conditioner.sv
// Directed bench for tug_press_conditioner with defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_tug_press_conditioner;

    logic clk;
    logic reset;
    logic key_l_n;
    logic key_r_n;
    logic enable;
    logic L;
    logic R;
    logic held_l;
    logic held_r;

    int n_checks = 0;
    int n_fail   = 0;

    int edge_idx;
    int l_cnt;
    int r_cnt;
    int l_first;
    int r_first;
    int held_r_seen;

    tug_press_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .enable (enable),
        .L      (L),
        .R      (R),
        .held_l (held_l),
        .held_r (held_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        edge_idx    = 0;
        l_cnt       = 0;
        r_cnt       = 0;
        l_first     = -1;
        r_first     = -1;
        held_r_seen = 0;
    endtask

    // One clock edge; pulses are tallied with the edge index they appeared on.
    task automatic step();
        @(posedge clk);
        #1;
        if (L === 1'b1) begin
            l_cnt++;
            if (l_first < 0) l_first = edge_idx;
        end
        if (R === 1'b1) begin
            r_cnt++;
            if (r_first < 0) r_first = edge_idx;
        end
        if (held_r === 1'b1) held_r_seen = 1;
        edge_idx++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset   = 1'b1;
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        enable  = 1'b1;
        clear_stats();
        steps(3);
        check("rst_L", L, 0);
        check("rst_R", R, 0);
        check("rst_held_l", held_l, 0);
        check("rst_held_r", held_r, 0);
        reset = 1'b0;
        steps(10);

        // Clean left press: pulse exactly on edge 5, held from edge 5.
        clear_stats();
        key_l_n = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            check($sformatf("press_L_e%0d", e), L, (e == 5) ? 1 : 0);
            check($sformatf("press_held_l_e%0d", e), held_l, (e >= 5) ? 1 : 0);
        end
        check("press_R_cnt", r_cnt, 0);
        key_l_n = 1'b1;
        steps(10);
        check("release_held_l", held_l, 0);
        check("release_L_cnt", l_cnt, 1);

        // Right glitch 3 sampled cycles: rejected.
        clear_stats();
        key_r_n = 1'b0;
        steps(3);
        key_r_n = 1'b1;
        steps(12);
        check("glitch3_R_cnt", r_cnt, 0);
        check("glitch3_held_r", held_r_seen, 0);

        // Right low for exactly 4 sampled cycles: accepted once.
        clear_stats();
        key_r_n = 1'b0;
        steps(4);
        key_r_n = 1'b1;
        steps(15);
        check("glitch4_R_cnt", r_cnt, 1);
        check("glitch4_R_edge", r_first, 5);
        check("glitch4_held_r_end", held_r, 0);

        // Bouncy press settling at edge 4, then a 2-cycle release blip mid-hold.
        clear_stats();
        key_l_n = 1'b0; step();
        key_l_n = 1'b1; step();
        key_l_n = 1'b0; step();
        key_l_n = 1'b1; step();
        key_l_n = 1'b0;
        steps(16);
        check("bounce_L_cnt", l_cnt, 1);
        check("bounce_L_edge", l_first, 9);
        key_l_n = 1'b1;
        steps(2);
        key_l_n = 1'b0;
        steps(10);
        check("blip_L_cnt", l_cnt, 1);
        check("blip_held_l", held_l, 1);
        key_l_n = 1'b1;
        steps(10);
        check("bounce_release_held_l", held_l, 0);

        // Press while disabled, enable while held: no pulse until a fresh press.
        clear_stats();
        enable  = 1'b0;
        key_l_n = 1'b0;
        steps(10);
        check("dis_held_l", held_l, 1);
        enable = 1'b1;
        steps(10);
        check("dis_L_cnt", l_cnt, 0);
        key_l_n = 1'b1;
        steps(10);
        key_l_n = 1'b0;
        steps(10);
        check("repress_L_cnt", l_cnt, 1);
        key_l_n = 1'b1;
        steps(10);

        // Right key held through reset: locked out until released and re-pressed.
        key_r_n = 1'b0;
        steps(3);
        reset = 1'b1;
        steps(3);
        check("rst_held_r_mid", held_r, 0);
        reset = 1'b0;
        clear_stats();
        steps(20);
        check("lock_R_cnt", r_cnt, 0);
        check("lock_held_r", held_r, 1);
        key_r_n = 1'b1;
        steps(10);
        check("lock_release_held_r", held_r, 0);
        check("lock_release_R_cnt", r_cnt, 0);
        key_r_n = 1'b0;
        steps(10);
        check("lock_repress_R_cnt", r_cnt, 1);
        key_r_n = 1'b1;
        steps(10);

        // Both keys on the same edge: coincident single pulses.
        clear_stats();
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        steps(10);
        check("both_L_cnt", l_cnt, 1);
        check("both_R_cnt", r_cnt, 1);
        check("both_L_edge", l_first, 5);
        check("both_R_edge", r_first, 5);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        steps(10);
        check("both_release_L", held_l, 0);
        check("both_release_R", held_r, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
